muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; legal values are even and 8..64.
REQ-002 Parameter: CNT_W, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: rst  in  1  reset; asynchronous, active-low (asserted at 0).
REQ-005 Port: start  in  1  request a new operation; sampled only in IDLE.
REQ-006 Port: op  in  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-007 Port: a  in  WIDTH  multiplicand / dividend.
REQ-008 Port: b  in  WIDTH  multiplier / divisor.
REQ-009 Port: flush  in  1  abort the in-flight operation (pipeline kill).
REQ-010 Port: hi_we, lo_we  in  1 each  MTHI/MTLO write strobes.
REQ-011 Port: wdata  in  WIDTH  MTHI/MTLO write data.
REQ-012 Port: busy  out  1  operation in progress; the pipeline stalls on it.
REQ-013 Port: done  out  1  one-cycle pulse; hi/lo hold a new result.
REQ-014 Port: dz  out  1  last completed DIV/DIVU had divisor 0; held until next completion.
REQ-015 Port: hi, lo  out  WIDTH each  registered HI/LO architectural state.

Function
REQ-016 The state machine SHALL have states IDLE, PREP, CALC, FIX, DONE.
REQ-017 Transitions SHALL be: IDLE->PREP on start&!flush; PREP->CALC; CALC->FIX after WIDTH iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-018 PREP SHALL latch op and take absolute values of a and b for signed ops; for unsigned ops it SHALL take them unchanged.
REQ-019 Multiply SHALL use one shift-add step per CALC cycle; divide SHALL use one restoring shift-subtract step per CALC cycle.
REQ-020 FIX SHALL negate the 2*WIDTH product when operand signs differ; for DIV it SHALL negate the quotient when signs differ and the remainder when a<0.
REQ-021 All arithmetic SHALL be modulo 2^WIDTH, so DIV MIN/-1 yields lo=MIN, hi=0, with no flag.
REQ-022 Division by zero SHALL yield lo=all-ones, hi=a (raw), dz=1.
REQ-023 MULT/MULTU SHALL set hi={product[2W-1:W]} and lo={product[W-1:0]}; DIV SHALL set lo=quotient and hi=remainder.
REQ-024 hi/lo/dz SHALL update on the FIX->DONE edge, exactly WIDTH+2 rising edges after the accepting edge (34 for WIDTH=32).
REQ-025 busy SHALL be 1 in PREP, CALC and FIX, and 0 in IDLE and DONE.
REQ-026 done SHALL be 1 only in DONE.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 flush in PREP, CALC or FIX SHALL force IDLE on the next edge, leave hi/lo/dz unchanged, and produce no done.
REQ-029 flush together with start in IDLE SHALL not accept the start.
REQ-030 hi_we/lo_we SHALL write wdata on the next edge in IDLE or DONE; in PREP or CALC they SHALL be ignored.
REQ-031 On the FIX->DONE edge the result SHALL win over a simultaneous hi_we/lo_we.
REQ-032 hi_we and lo_we together SHALL write the same wdata to both registers.
REQ-033 Operands SHALL be captured at acceptance; a/b/op changes afterwards SHALL not affect the result.

Reset
REQ-034 rst=0 SHALL asynchronously force state=IDLE, busy=0, done=0, dz=0, hi=0, lo=0, and clear the counter and all working registers.
REQ-035 Reset mid-operation SHALL discard the operation; no done SHALL follow release.
REQ-036 The first start SHALL be accepted on the first rising edge with rst=1.

Structure
REQ-037 Package muldiv_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state enum.
REQ-038 Sub-module muldiv_iter SHALL implement the per-cycle shift-add/shift-subtract datapath step, parametrised by WIDTH; the FSM, sign handling and HI/LO registers SHALL stay in muldiv_unit.
REQ-039 The unit SHALL contain no combinational path from inputs to outputs; all outputs SHALL be registered or decoded from state.

Verification (WIDTH=32)
REQ-040 MULT a=FFFFFFFE b=00000003 -> done on edge 34, hi=FFFFFFFF, lo=FFFFFFFA, dz=0.
REQ-041 MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-042 DIV a=FFFFFFF9 (-7) b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-043 DIVU a=00000005 b=0 -> lo=FFFFFFFF, hi=00000005, dz=1; the next valid DIVU SHALL clear dz.
REQ-044 Flush at edge 10 of an operation -> IDLE, no done, hi/lo unchanged; start at edge 12 -> normal completion; start while busy -> ignored.
REQ-045 hi_we with wdata=12345678 on the FIX cycle -> result kept; rst=0 at edge 20 -> all outputs 0 and no done afterwards.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_nx,
  output logic [WIDTH-1:0] q_nx
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] sub;
  logic             ge;

  always_comb begin
    sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    sh  = {acc, q[WIDTH-1]};
    ge  = (sh >= {1'b0, m});
    // Remainder is always below the divisor, so the subtraction fits in WIDTH bits.
    sub = sh[WIDTH-1:0] - m;
    if (div) begin
      acc_nx = ge ? sub : sh[WIDTH-1:0];
      q_nx   = {q[WIDTH-2:0], ge};
    end else begin
      acc_nx = sum[WIDTH:1];
      q_nx   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO architectural registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r, acc, q, m;
  logic [WIDTH-1:0]   acc_nx, q_nx, abs_a, abs_b, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_raw, prod;
  logic               is_div, neg_a, neg_b, div_zero;

  assign is_div   = op_is_div(op_r);
  assign neg_a    = op_is_signed(op_r) & a_r[WIDTH-1];
  assign neg_b    = op_is_signed(op_r) & b_r[WIDTH-1];
  assign abs_a    = neg_a ? -a_r : a_r;
  assign abs_b    = neg_b ? -b_r : b_r;
  assign div_zero = (b_r == '0);
  assign prod_raw = {acc, q};
  assign prod     = (neg_a ^ neg_b) ? -prod_raw : prod_raw;

  // Divide-by-zero bypasses the sign fix so hi returns the untouched dividend.
  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = a_r;
        res_lo = '1;
      end else begin
        res_hi = neg_a ? -acc : acc;
        res_lo = (neg_a ^ neg_b) ? -q : q;
      end
    end
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .div    (is_div),
    .acc    (acc),
    .q      (q),
    .m      (m),
    .acc_nx (acc_nx),
    .q_nx   (q_nx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_r  <= '0;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      hi    <= '0;
      lo    <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          state <= PREP;
          op_r  <= op;
          a_r   <= a;
          b_r   <= b;
        end
        PREP: if (flush) state <= IDLE;
        else begin
          state <= CALC;
          acc   <= '0;
          q     <= abs_a;
          m     <= abs_b;
          cnt   <= '0;
        end
        CALC: if (flush) state <= IDLE;
        else begin
          acc <= acc_nx;
          q   <= q_nx;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: if (flush) state <= IDLE;
        else begin
          state <= DONE;
          hi    <= res_hi;
          lo    <= res_lo;
          dz    <= is_div & div_zero;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (state == IDLE || state == DONE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

  assign busy = (state == PREP) || (state == CALC) || (state == FIX);
  assign done = (state == DONE);

endmodule
